demux_channel_collector: RTL and testbench

Four-channel deserializer that sits directly downstream of the 1:4 demultiplexer. It consumes the demux select `S` and outputs `Y[3:0]`, and on each qualified sample shifts the routed bit into that channel's shift register. After WIDTH bits a channel's word is complete; it is buffered per channel and then delivered one word at a time on a single valid/ready output port. Channels are served in round-robin order.

---
 rtl/demux_channel_collector.sv | 152 +++++++++++++++
 tb/tb_demux_channel_collector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_channel_collector.sv
// demux_channel_collector: four-channel deserializer behind a 1:4 demux.
// Each channel shifts its routed bit LSB-first into a private shift register.
// A completed word parks in a one-deep per-channel hold buffer. A round-robin
// arbiter then moves held words into a single registered valid/ready port.

// Per-channel lane: shift register, bit counter, hold buffer, sticky overflow.
module demux_chan_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,     // this lane is selected and in_valid is high
  input  logic             bit_in,     // Y[S], meaningful only when sample is high
  input  logic             take,       // arbiter moves hold to the output register this edge
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] hold,
  output logic             hold_full,
  output logic             overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             drop;

  assign word     = {bit_in, sr[WIDTH-1:1]};
  assign complete = sample && (cnt == CW'(WIDTH - 1));
  // The hold slot can take a new word when it is empty, or when it drains on the same edge.
  assign drop     = complete && hold_full && !take;

  // Shift the sampled bit in from the top and count bits toward a full word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (sample) begin
      sr  <= word;
      cnt <= complete ? '0 : cnt + CW'(1);
    end
  end

  // Load completed words into hold; release the slot when the arbiter takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (complete && (!hold_full || take)) begin
      hold      <= word;
      hold_full <= 1'b1;
    end else if (take) begin
      hold_full <= 1'b0;
    end
  end

  // Sticky drop flag: a new drop on this edge beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end
endmodule

module demux_channel_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       S,
  input  logic [3:0]       Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_chan,
  output logic [3:0]       overflow,
  input  logic             clr_ovf
);
  localparam int NUM_CH = 4;

  typedef struct packed {
    logic [1:0]       chan;
    logic [WIDTH-1:0] data;
  } out_word_t;

  logic [NUM_CH-1:0]            sample;
  logic [NUM_CH-1:0]            take;
  logic [NUM_CH-1:0]            hold_full;
  logic [NUM_CH-1:0][WIDTH-1:0] hold;
  logic                         bit_in;
  logic [1:0]                   last;
  logic [1:0]                   pick;
  logic                         any_pending;
  logic                         out_free;
  out_word_t                    out_q;

  assign bit_in   = Y[S];
  assign out_free = !out_valid || out_ready;
  assign out_data = out_q.data;
  assign out_chan = out_q.chan;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign sample[c] = in_valid && (S == 2'(c));
    assign take[c]   = out_free && any_pending && (pick == 2'(c));

    demux_chan_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .sample    (sample[c]),
      .bit_in    (bit_in),
      .take      (take[c]),
      .clr_ovf   (clr_ovf),
      .hold      (hold[c]),
      .hold_full (hold_full[c]),
      .overflow  (overflow[c])
    );
  end

  // Round-robin pick: the first full hold slot after the last channel served.
  always_comb begin
    logic [1:0] idx;
    idx         = '0;
    pick        = '0;
    any_pending = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = last + 2'(i);
      if (!any_pending && hold_full[idx]) begin
        pick        = idx;
        any_pending = 1'b1;
      end
    end
  end

  // Output register: refill from the arbiter whenever it is empty or being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      last      <= 2'd3;
    end else if (out_free) begin
      if (any_pending) begin
        out_valid  <= 1'b1;
        out_q.chan <= pick;
        out_q.data <= hold[pick];
        last       <= pick;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_demux_channel_collector.sv
// Bench for demux_channel_collector: scoreboard of expected words, plus
// direct checks of latency, round-robin order, overflow and async reset.
module tb_demux_channel_collector;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] S;
  logic [3:0] Y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_chan;
  logic [3:0] overflow;
  logic       clr_ovf;

  typedef struct {
    logic [1:0] chan;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  demux_channel_collector #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .S         (S),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Drive one sample on channel ch; the other Y bits carry noise.
  task automatic send_bit(input logic [1:0] ch, input logic b);
    in_valid = 1'b1;
    S        = ch;
    Y        = 4'($urandom);
    Y[ch]    = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    Y        = 4'($urandom);
  endtask

  task automatic send_bits(input logic [1:0] ch, input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(ch, w[i]);
  endtask

  task automatic send_word(input logic [1:0] ch, input logic [7:0] w, input bit push);
    exp_t e;
    if (push) begin
      e.chan = ch;
      e.data = w;
      q.push_back(e);
    end
    send_bits(ch, w, 8);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (q.size() != 0 && k < 60) begin
      idle(1);
      k++;
    end
    idle(2);
    chk(tag, q.size(), 0);
  endtask

  // Scoreboard monitor: every handshake pops one expected word.
  logic       held_prev = 1'b0;
  logic [7:0] held_data;
  logic [1:0] held_chan;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (held_prev) begin
        chk("stall_data", out_data, held_data);
        chk("stall_chan", out_chan, held_chan);
      end
      if (out_ready) begin
        if (q.size() == 0) chk("unexpected_word", {out_chan, out_data}, 0);
        else begin
          e = q.pop_front();
          chk("sb_chan", out_chan, e.chan);
          chk("sb_data", out_data, e.data);
        end
      end
    end
    held_prev = !rst && out_valid && !out_ready;
    held_data = out_data;
    held_chan = out_chan;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] w1, w2;
    rst = 1'b1; in_valid = 1'b0; S = '0; Y = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_ovf",   overflow,  0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single word and its latency
    out_ready = 1'b1;
    q.push_back('{2'd0, 8'hA5});
    send_bits(2'd0, 8'hA5, 8);
    chk("t1_latency_lo", out_valid, 0);
    idle(1);
    chk("t1_valid", out_valid, 1);
    chk("t1_data",  out_data,  8'hA5);
    chk("t1_chan",  out_chan,  0);
    chk("t1_ovf",   overflow,  0);
    drain("t1_drain");

    // 2: interleaved ch1/ch2 with idle gaps
    w1 = 8'h3C; w2 = 8'hC3;
    q.push_back('{2'd1, 8'h3C});
    q.push_back('{2'd2, 8'hC3});
    for (int i = 0; i < 8; i++) begin
      send_bit(2'd1, w1[i]);
      idle(1);
      send_bit(2'd2, w2[i]);
      if (i % 3 == 0) idle(2);
    end
    drain("t2_drain");

    // 3: overflow on ch0, then drain exactly two words, then clear
    out_ready = 1'b0;
    send_word(2'd0, 8'h11, 1'b1);
    send_word(2'd0, 8'h22, 1'b1);
    chk("t3_no_ovf_yet", overflow, 0);
    send_word(2'd0, 8'h33, 1'b0);
    chk("t3_ovf", overflow, 4'b0001);
    out_ready = 1'b1;
    drain("t3_drain");
    chk("t3_ovf_sticky", overflow, 4'b0001);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", overflow, 0);

    // 4: round-robin delivery back to back
    out_ready = 1'b0;
    send_word(2'd0, 8'h10, 1'b1);
    send_word(2'd1, 8'h20, 1'b1);
    send_word(2'd2, 8'h30, 1'b1);
    send_word(2'd3, 8'h40, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_valid", out_valid, 1);
      chk("t4_chan",  out_chan,  i);
      chk("t4_data",  out_data,  8'h10 * (i + 1));
      idle(1);
    end
    drain("t4_drain");

    // 5: async reset mid-word with a word stalled in the output register
    out_ready = 1'b0;
    send_word(2'd1, 8'h77, 1'b1);
    idle(1);
    chk("t5_pre_valid", out_valid, 1);
    send_bits(2'd3, 8'hFF, 4);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_data",  out_data,  0);
    chk("t5_rst_chan",  out_chan,  0);
    chk("t5_rst_ovf",   overflow,  0);
    q.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_word(2'd3, 8'h5A, 1'b1);
    drain("t5_drain");

    // 6: ch2 completion on the same edge its hold slot transfers out
    out_ready = 1'b0;
    send_word(2'd0, 8'h0F, 1'b1);
    send_word(2'd2, 8'h81, 1'b1);
    q.push_back('{2'd2, 8'h7E});
    send_bits(2'd2, 8'h7E, 7);
    out_ready = 1'b1;
    w1 = 8'h7E;
    send_bit(2'd2, w1[7]);
    chk("t6_ovf_edge", overflow, 0);
    drain("t6_drain");
    chk("t6_ovf", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
